// File: rtl/data_sram_resp_pkg.sv
// ---------------------------------------------------------------------------
// data_sram_resp_pkg
// Shared defines for the data-side SRAM responder: load/store opcode
// encodings, the default array depth, and the helpers that turn a store
// opcode plus address into a byte-lane mask and lane-positioned data.
// ---------------------------------------------------------------------------
package data_sram_resp_pkg;

  localparam int DEPTH_WORDS_DEFAULT = 1024;

  typedef enum logic [3:0] {
    LSOP_NOP = 4'b0000,
    LSOP_LB  = 4'b0001,
    LSOP_LBU = 4'b0010,
    LSOP_LH  = 4'b0011,
    LSOP_LHU = 4'b0100,
    LSOP_LW  = 4'b0101,
    LSOP_SB  = 4'b0110,
    LSOP_SH  = 4'b0111,
    LSOP_SW  = 4'b1000
  } lsop_e;

  // Byte-enable mask for a store, selected by the low address bits.
  function automatic logic [3:0] store_mask(lsop_e op, logic [1:0] addr_lo);
    logic [3:0] m;
    m = 4'b0000;
    case (op)
      LSOP_SB: m = 4'b0001 << addr_lo;
      LSOP_SH: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      LSOP_SW: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate right-aligned store data so every candidate lane carries it;
  // the mask then picks which lanes actually get written.
  function automatic logic [31:0] store_data(lsop_e op, logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    case (op)
      LSOP_SB: d = {4{wdata[7:0]}};
      LSOP_SH: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_sram_resp_store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Two-entry FIFO of pending stores with load forwarding overlay.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enq, enq_idx/mask/data    push one entry (caller guarantees not full)
//   drain                     pop the head entry (caller guarantees not empty)
//   head_idx/mask/data        oldest entry, written to the array on drain
//   count                     occupancy 0..2
//   lookup_idx, array_word    word being loaded and its raw array value
//   merged_word               array_word with buffered bytes overlaid
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic [IDX_W-1:0] enq_idx,
  input  logic [3:0]       enq_mask,
  input  logic [31:0]      enq_data,
  input  logic             drain,
  output logic [IDX_W-1:0] head_idx,
  output logic [3:0]       head_mask,
  output logic [31:0]      head_data,
  output logic [1:0]       count,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [31:0]      array_word,
  output logic [31:0]      merged_word
);

  logic [IDX_W-1:0] ent_idx  [2];
  logic [3:0]       ent_mask [2];
  logic [31:0]      ent_data [2];
  logic             wr_ptr;
  logic             rd_ptr;

  function automatic logic [31:0] overlay(logic [31:0] w, logic [3:0] m, logic [31:0] d);
    logic [31:0] r;
    r = w;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // Pointer and occupancy bookkeeping; reset alone discards all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq)   wr_ptr <= ~wr_ptr;
      if (drain) rd_ptr <= ~rd_ptr;
      if (enq && !drain)      count <= count + 2'd1;
      else if (drain && !enq) count <= count - 2'd1;
    end
  end

  // Entry payload needs no reset: it is only visible while counted valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_idx[wr_ptr]  <= enq_idx;
      ent_mask[wr_ptr] <= enq_mask;
      ent_data[wr_ptr] <= enq_data;
    end
  end

  assign head_idx  = ent_idx[rd_ptr];
  assign head_mask = ent_mask[rd_ptr];
  assign head_data = ent_data[rd_ptr];

  // Older entry is applied first so the younger one wins on shared bytes.
  always_comb begin
    merged_word = array_word;
    if (count != 2'd0 && ent_idx[rd_ptr] == lookup_idx)
      merged_word = overlay(merged_word, ent_mask[rd_ptr], ent_data[rd_ptr]);
    if (count == 2'd2 && ent_idx[~rd_ptr] == lookup_idx)
      merged_word = overlay(merged_word, ent_mask[~rd_ptr], ent_data[~rd_ptr]);
  end

endmodule

// File: rtl/data_sram_resp.sv
// ---------------------------------------------------------------------------
// data_sram_resp
// Word-organised data SRAM for the CPU MEM stage with a two-entry store
// buffer. Loads answer combinationally (array plus forwarded stores);
// stores are buffered and drained into the array on idle or stalled cycles.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ram_ce_i/we_i   access request / store select
//   ram_addr_i      byte address (word index wraps modulo DEPTH_WORDS)
//   ram_wdata_i     right-aligned store data
//   lsop_i          load/store opcode
//   ram_rdata_o     extended load result (0 when not a valid load)
//   stall_o         store refused, buffer full
//   misalign_o      access misaligned and suppressed
//   sb_count_o      store-buffer occupancy
// ---------------------------------------------------------------------------
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_wdata_i,
  input  logic [3:0]  lsop_i,
  output logic [31:0] ram_rdata_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [1:0]  sb_count_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  lsop_e            op;
  logic             is_load;
  logic             is_store;
  logic             is_half;
  logic             is_word;
  logic [IDX_W-1:0] word_idx;
  logic             store_ok;
  logic             enq;
  logic             drain;
  logic [IDX_W-1:0] head_idx;
  logic [3:0]       head_mask;
  logic [31:0]      head_data;
  logic [31:0]      array_word;
  logic [31:0]      merged_word;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic             unused_addr_bits;

  logic [31:0] mem [DEPTH_WORDS];

  assign op               = lsop_e'(lsop_i);
  assign word_idx         = ram_addr_i[IDX_W+1:2];
  assign unused_addr_bits = &{1'b0, ram_addr_i[31:IDX_W+2]};

  // Opcode class decode; unlisted encodings fall through as NOP.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (op)
      LSOP_LB, LSOP_LBU: is_load = 1'b1;
      LSOP_LH, LSOP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      LSOP_LW:           begin is_load = 1'b1; is_word = 1'b1; end
      LSOP_SB:           is_store = 1'b1;
      LSOP_SH:           begin is_store = 1'b1; is_half = 1'b1; end
      LSOP_SW:           begin is_store = 1'b1; is_word = 1'b1; end
      default:           ;
    endcase
  end

  assign misalign_o = ram_ce_i && ((is_half && ram_addr_i[0]) ||
                                   (is_word && ram_addr_i[1:0] != 2'b00));

  // An aligned store request; whether it is taken depends on buffer room.
  // Enqueue needs a request while drain needs none (or a stall), so the
  // two can never coincide.
  assign store_ok = ram_ce_i && ram_we_i && is_store && !misalign_o;
  assign stall_o  = !rst && store_ok && (sb_count_o == 2'd2);
  assign enq      = !rst && store_ok && (sb_count_o != 2'd2);
  assign drain    = !rst && (sb_count_o != 2'd0) && (!ram_ce_i || stall_o);

  store_buffer #(.IDX_W(IDX_W)) u_store_buffer (
    .clk         (clk),
    .rst         (rst),
    .enq         (enq),
    .enq_idx     (word_idx),
    .enq_mask    (store_mask(op, ram_addr_i[1:0])),
    .enq_data    (store_data(op, ram_wdata_i)),
    .drain       (drain),
    .head_idx    (head_idx),
    .head_mask   (head_mask),
    .head_data   (head_data),
    .count       (sb_count_o),
    .lookup_idx  (word_idx),
    .array_word  (array_word),
    .merged_word (merged_word)
  );

  // Array is never reset; drained entries write only their masked bytes.
  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (head_mask[b]) mem[head_idx][8*b +: 8] <= head_data[8*b +: 8];
      end
    end
  end

  assign array_word = mem[word_idx];

  // Lane selection and extension of the forwarded word.
  always_comb begin
    lane_byte   = merged_word[7:0];
    lane_half   = ram_addr_i[1] ? merged_word[31:16] : merged_word[15:0];
    ram_rdata_o = 32'd0;
    case (ram_addr_i[1:0])
      2'd0:    lane_byte = merged_word[7:0];
      2'd1:    lane_byte = merged_word[15:8];
      2'd2:    lane_byte = merged_word[23:16];
      default: lane_byte = merged_word[31:24];
    endcase
    if (ram_ce_i && !ram_we_i && !misalign_o && is_load) begin
      case (op)
        LSOP_LB:  ram_rdata_o = {{24{lane_byte[7]}}, lane_byte};
        LSOP_LBU: ram_rdata_o = {24'd0, lane_byte};
        LSOP_LH:  ram_rdata_o = {{16{lane_half[15]}}, lane_half};
        LSOP_LHU: ram_rdata_o = {16'd0, lane_half};
        default:  ram_rdata_o = merged_word;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// ---------------------------------------------------------------------------
// tb_data_sram_resp
// Bench for data_sram_resp. A byte-addressed memory model plus a queue of
// pending stores predicts every output each cycle; directed sequences with
// hand-worked literal results pin the model.
// ---------------------------------------------------------------------------
module tb_data_sram_resp;

  localparam int DEPTH_BYTES = 4096;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LBU = 4'b0010;
  localparam logic [3:0] OP_LH  = 4'b0011;
  localparam logic [3:0] OP_LHU = 4'b0100;
  localparam logic [3:0] OP_LW  = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b0110;
  localparam logic [3:0] OP_SH  = 4'b0111;
  localparam logic [3:0] OP_SW  = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_ce_i;
  logic        ram_we_i;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_wdata_i;
  logic [3:0]  lsop_i;
  logic [31:0] ram_rdata_o;
  logic        stall_o;
  logic        misalign_o;
  logic [1:0]  sb_count_o;

  int n_checks = 0;
  int n_errors = 0;
  bit run_cmp  = 1'b0;

  typedef struct {
    int unsigned addr;
    int unsigned size;
    logic [31:0] data;
  } pend_t;

  pend_t      pend [$];
  logic [7:0] mem_m [DEPTH_BYTES];

  data_sram_resp dut (
    .clk         (clk),
    .rst         (rst),
    .ram_ce_i    (ram_ce_i),
    .ram_we_i    (ram_we_i),
    .ram_addr_i  (ram_addr_i),
    .ram_wdata_i (ram_wdata_i),
    .lsop_i      (lsop_i),
    .ram_rdata_o (ram_rdata_o),
    .stall_o     (stall_o),
    .misalign_o  (misalign_o),
    .sb_count_o  (sb_count_o)
  );

  always #5 clk = ~clk;

  // Opcode arithmetic used by the model.
  function automatic int unsigned op_size(logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit op_is_load(logic [3:0] op);
    return op >= OP_LB && op <= OP_LW;
  endfunction

  function automatic bit op_is_store(logic [3:0] op);
    return op >= OP_SB && op <= OP_SW;
  endfunction

  function automatic bit m_misalign(logic ce, logic [3:0] op, logic [31:0] addr);
    int unsigned sz;
    sz = op_size(op);
    return ce && sz > 1 && ((addr % sz) != 0);
  endfunction

  function automatic bit m_store_ok(logic ce, logic we, logic [3:0] op, logic [31:0] addr);
    return ce && we && op_is_store(op) && !m_misalign(ce, op, addr);
  endfunction

  // Byte as seen by a load: memory, then pending stores oldest to youngest.
  function automatic logic [7:0] read_byte(int unsigned a);
    logic [7:0] v;
    v = mem_m[a];
    foreach (pend[i]) begin
      if (a >= pend[i].addr && a < pend[i].addr + pend[i].size)
        v = pend[i].data[8*(a - pend[i].addr) +: 8];
    end
    return v;
  endfunction

  function automatic logic [31:0] model_load(logic [3:0] op, logic [31:0] addr);
    int unsigned a;
    logic [31:0] v;
    a = addr % DEPTH_BYTES;
    v = 32'd0;
    for (int k = 0; k < int'(op_size(op)); k++) v[8*k +: 8] = read_byte(a + k);
    case (op)
      OP_LB:   return {{24{v[7]}}, v[7:0]};
      OP_LBU:  return {24'd0, v[7:0]};
      OP_LH:   return {{16{v[15]}}, v[15:0]};
      OP_LHU:  return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model state advances on the same edge as the design.
  always @(posedge clk) begin
    bit ok;
    ok = m_store_ok(ram_ce_i, ram_we_i, lsop_i, ram_addr_i);
    if (rst) begin
      pend.delete();
    end else if (ok && pend.size() < 2) begin
      pend.push_back('{addr: ram_addr_i % DEPTH_BYTES, size: op_size(lsop_i), data: ram_wdata_i});
    end else if (pend.size() > 0 && (!ram_ce_i || ok)) begin
      pend_t p;
      p = pend.pop_front();
      for (int k = 0; k < int'(p.size); k++) mem_m[p.addr + k] = p.data[8*k +: 8];
    end
  end

  // Every mid-cycle, compare all outputs against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      bit          ok;
      bit          mis;
      logic [31:0] exp_rd;
      ok     = m_store_ok(ram_ce_i, ram_we_i, lsop_i, ram_addr_i);
      mis    = m_misalign(ram_ce_i, lsop_i, ram_addr_i);
      exp_rd = (ram_ce_i && !ram_we_i && !mis && op_is_load(lsop_i)) ?
               model_load(lsop_i, ram_addr_i) : 32'd0;
      checkOutput("model_misalign", {31'd0, misalign_o}, {31'd0, mis});
      checkOutput("model_stall", {31'd0, stall_o}, {31'd0, (!rst && ok && pend.size() == 2)});
      checkOutput("model_count", {30'd0, sb_count_o}, pend.size());
      if (!$isunknown(exp_rd)) checkOutput("model_rdata", ram_rdata_o, exp_rd);
    end
  end

  task automatic applyStimulus(input logic ce, input logic we, input logic [3:0] op,
                               input logic [31:0] addr, input logic [31:0] wdata);
    ram_ce_i    = ce;
    ram_we_i    = we;
    lsop_i      = op;
    ram_addr_i  = addr;
    ram_wdata_i = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0);
    tick();
    run_cmp = 1'b1;
    tick();
    rst = 1'b0;
    #2 checkOutput("reset_count", {30'd0, sb_count_o}, 32'd0);
    tick();

    // Forwarding from a still-buffered word store
    applyStimulus(1'b1, 1'b1, OP_SW, 32'h10, 32'h11223344); tick();
    applyStimulus(1'b1, 1'b0, OP_LB, 32'h13, 32'd0);
    #2 checkOutput("fwd_lb_13", ram_rdata_o, 32'h00000011);
    checkOutput("fwd_count", {30'd0, sb_count_o}, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, OP_LB, 32'h10, 32'd0);
    #2 checkOutput("fwd_lb_10", ram_rdata_o, 32'h00000044);
    tick();
    applyStimulus(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0); tick(); tick();

    // Byte store over word store, then drained half loads
    applyStimulus(1'b1, 1'b1, OP_SW, 32'h20, 32'hFFFFFFFF); tick();
    applyStimulus(1'b1, 1'b1, OP_SB, 32'h21, 32'h00000080); tick();
    applyStimulus(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0); tick(); tick();
    applyStimulus(1'b1, 1'b0, OP_LH, 32'h20, 32'd0);
    #2 checkOutput("lh_20", ram_rdata_o, 32'hFFFF80FF);
    tick();
    applyStimulus(1'b1, 1'b0, OP_LHU, 32'h20, 32'd0);
    #2 checkOutput("lhu_20", ram_rdata_o, 32'h000080FF);
    tick();
    applyStimulus(1'b1, 1'b0, OP_LB, 32'h21, 32'd0);
    #2 checkOutput("lb_21", ram_rdata_o, 32'hFFFFFF80);
    tick();
    applyStimulus(1'b1, 1'b0, OP_LBU, 32'h21, 32'd0);
    #2 checkOutput("lbu_21", ram_rdata_o, 32'h00000080);
    tick();

    // Three back-to-back stores: third stalls, then is accepted
    applyStimulus(1'b1, 1'b1, OP_SW, 32'h40, 32'hA0000001); tick();
    applyStimulus(1'b1, 1'b1, OP_SW, 32'h44, 32'hA0000002); tick();
    applyStimulus(1'b1, 1'b1, OP_SW, 32'h48, 32'hA0000003);
    #2 checkOutput("full_stall", {31'd0, stall_o}, 32'd1);
    checkOutput("full_count", {30'd0, sb_count_o}, 32'd2);
    tick();
    #2 checkOutput("retry_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("retry_count", {30'd0, sb_count_o}, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, OP_LW, 32'h40, 32'd0);
    #2 checkOutput("after_retry_count", {30'd0, sb_count_o}, 32'd2);
    checkOutput("lw_40_drained", ram_rdata_o, 32'hA0000001);
    tick();
    applyStimulus(1'b1, 1'b0, OP_LW, 32'h48, 32'd0);
    #2 checkOutput("lw_48_fwd", ram_rdata_o, 32'hA0000003);
    tick();
    applyStimulus(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0); tick(); tick(); tick();
    checkOutput("drained_count", {30'd0, sb_count_o}, 32'd0);

    // Misaligned accesses are suppressed
    applyStimulus(1'b1, 1'b0, OP_LW, 32'h6, 32'd0);
    #2 checkOutput("mis_lw_flag", {31'd0, misalign_o}, 32'd1);
    checkOutput("mis_lw_rdata", ram_rdata_o, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, OP_SH, 32'h3, 32'h0000BEEF);
    #2 checkOutput("mis_sh_flag", {31'd0, misalign_o}, 32'd1);
    checkOutput("mis_sh_stall", {31'd0, stall_o}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, OP_SW, 32'h22, 32'h00000000);
    #2 checkOutput("mis_sw_flag", {31'd0, misalign_o}, 32'd1);
    tick();
    checkOutput("mis_count", {30'd0, sb_count_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0); tick();
    applyStimulus(1'b1, 1'b0, OP_LW, 32'h20, 32'd0);
    #2 checkOutput("mis_array_intact", ram_rdata_o, 32'hFFFF80FF);
    tick();

    // Upper-half store forwarded into a word load
    applyStimulus(1'b1, 1'b1, OP_SH, 32'h22, 32'h00001234); tick();
    applyStimulus(1'b1, 1'b0, OP_LW, 32'h20, 32'd0);
    #2 checkOutput("fwd_sh_lw", ram_rdata_o, 32'h123480FF);
    tick();
    applyStimulus(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0); tick(); tick();

    // Reset discards buffered stores; array keeps the old words
    applyStimulus(1'b1, 1'b1, OP_SW, 32'h40, 32'hDEAD0000); tick();
    applyStimulus(1'b1, 1'b1, OP_SW, 32'h44, 32'hBEEF0000); tick();
    applyStimulus(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0);
    rst = 1'b1;
    #2 checkOutput("pre_reset_count", {30'd0, sb_count_o}, 32'd2);
    tick();
    rst = 1'b0;
    checkOutput("post_reset_count", {30'd0, sb_count_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, OP_LW, 32'h40, 32'd0);
    #2 checkOutput("post_reset_lw40", ram_rdata_o, 32'hA0000001);
    tick();
    applyStimulus(1'b1, 1'b0, OP_LW, 32'h44, 32'd0);
    #2 checkOutput("post_reset_lw44", ram_rdata_o, 32'hA0000002);
    tick();

    // Address wrap past the top of the array
    applyStimulus(1'b1, 1'b1, OP_SW, 32'h0, 32'hA5A5A5A5); tick();
    applyStimulus(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0); tick(); tick();
    applyStimulus(1'b1, 1'b0, OP_LW, 32'h1000, 32'd0);
    #2 checkOutput("wrap_lw", ram_rdata_o, 32'hA5A5A5A5);
    tick();

    // Non-load requests give zero read data
    applyStimulus(1'b1, 1'b1, OP_LW, 32'h0, 32'd0);
    #2 checkOutput("we_load_zero", ram_rdata_o, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'b1111, 32'h0, 32'd0);
    #2 checkOutput("undef_op_zero", ram_rdata_o, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, OP_LW, 32'h0, 32'd0);
    #2 checkOutput("ce_low_zero", ram_rdata_o, 32'd0);
    tick();
    tick();

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
